snake_line_renderer: RTL and testbench

SNAKE_LINE_RENDERER -- requirements
Module: snake_line_renderer

---
 rtl/snake_line_renderer.sv | 158 +++++++++++++++
 tb/tb_snake_line_renderer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/snake_line_renderer.sv
// Per-line sprite rasterizer for the snake game: scans a frame snapshot of segment
// positions during horizontal blanking and builds body/head pixel masks for the next row.
module snake_line_renderer #(
   parameter int SEG_SIZE = 10,
   parameter int MAX_SEG  = 100,
   parameter int H_ACTIVE = 640
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [MAX_SEG*10-1:0]   pos_x,
   input  logic [MAX_SEG*10-1:0]   pos_y,
   input  logic [9:0]              length,
   input  logic                    frame_start,
   input  logic                    line_start,
   input  logic [9:0]              line_y,
   input  logic [9:0]              pixel_x,
   output logic                    snake_body,
   output logic                    snake_head,
   output logic                    busy,
   output logic                    scan_done
);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, XFER = 2'd2} state_t;

   localparam logic [9:0]          MAX_LEN  = 10'(MAX_SEG);
   localparam logic [10:0]         SEG_W    = 11'(SEG_SIZE);
   localparam logic [10:0]         H_LIM    = 11'(H_ACTIVE);
   localparam logic [H_ACTIVE-1:0] SEG_ONES = {{(H_ACTIVE-SEG_SIZE){1'b0}}, {SEG_SIZE{1'b1}}};

   state_t                  state_q, state_d;
   logic [9:0]              idx_q, idx_d;
   logic [9:0]              line_q, line_d;
   logic [MAX_SEG*10-1:0]   snap_x_q, snap_y_q;
   logic [9:0]              snap_len_q;
   logic [H_ACTIVE-1:0]     work_body_q, work_body_d, work_head_q, work_head_d;
   logic [H_ACTIVE-1:0]     disp_body_q, disp_body_d, disp_head_q, disp_head_d;
   logic                    done_d, done_q, busy_q, body_q, head_q;

   logic [9:0]              seg_x_s, seg_y_s, len_clamp_s;
   logic                    line_hit_s, scan_last_s, px_ok_s;
   logic [H_ACTIVE-1:0]     seg_mask_s;

   assign seg_x_s     = snap_x_q[idx_q*10 +: 10];
   assign seg_y_s     = snap_y_q[idx_q*10 +: 10];
   assign line_hit_s  = ({1'b0, seg_y_s} <= {1'b0, line_q}) &&
                        ({1'b0, line_q} < ({1'b0, seg_y_s} + SEG_W));
   // Shifting a fixed-width vector drops bits past the visible edge, giving clipping for free.
   assign seg_mask_s  = SEG_ONES << seg_x_s;
   assign scan_last_s = (snap_len_q == 10'd0) || (idx_q == snap_len_q - 10'd1);
   assign len_clamp_s = (length > MAX_LEN) ? MAX_LEN : length;
   assign px_ok_s     = ({1'b0, pixel_x} < H_LIM);

   // Next-state logic: frame/line pulses take priority over the running scan.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      line_d      = line_q;
      work_body_d = work_body_q;
      work_head_d = work_head_q;
      disp_body_d = disp_body_q;
      disp_head_d = disp_head_q;
      done_d      = 1'b0;
      if (frame_start) begin
         disp_body_d = '0;
         disp_head_d = '0;
      end else begin
         disp_body_d = disp_body_q;
      end
      if (line_start) begin
         state_d     = SCAN;
         idx_d       = 10'd0;
         line_d      = line_y;
         work_body_d = '0;
         work_head_d = '0;
      end else if (frame_start) begin
         state_d = IDLE;
         idx_d   = 10'd0;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            SCAN: begin
               if (line_hit_s && (snap_len_q != 10'd0)) begin
                  work_body_d = work_body_q | seg_mask_s;
                  if (idx_q == 10'd0) begin
                     work_head_d = work_head_q | seg_mask_s;
                  end else begin
                     work_head_d = work_head_q;
                  end
               end else begin
                  work_body_d = work_body_q;
               end
               if (scan_last_s) begin
                  state_d = XFER;
               end else begin
                  idx_d = idx_q + 10'd1;
               end
            end
            XFER: begin
               disp_body_d = work_body_q;
               disp_head_d = work_head_q;
               done_d      = 1'b1;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, mask and registered-output update.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 10'd0;
         line_q      <= 10'd0;
         work_body_q <= '0;
         work_head_q <= '0;
         disp_body_q <= '0;
         disp_head_q <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         body_q      <= 1'b0;
         head_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         line_q      <= line_d;
         work_body_q <= work_body_d;
         work_head_q <= work_head_d;
         disp_body_q <= disp_body_d;
         disp_head_q <= disp_head_d;
         done_q      <= done_d;
         busy_q      <= (state_d != IDLE);
         body_q      <= px_ok_s ? disp_body_q[pixel_x] : 1'b0;
         head_q      <= px_ok_s ? disp_head_q[pixel_x] : 1'b0;
      end
   end

   // Frame snapshot: scans never look at the live position buses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         snap_x_q   <= '0;
         snap_y_q   <= '0;
         snap_len_q <= 10'd0;
      end else if (frame_start) begin
         snap_x_q   <= pos_x;
         snap_y_q   <= pos_y;
         snap_len_q <= len_clamp_s;
      end else begin
         snap_len_q <= snap_len_q;
      end
   end

   assign snake_body = body_q;
   assign snake_head = head_q;
   assign busy       = busy_q;
   assign scan_done  = done_q;

endmodule

// File: tb/tb_snake_line_renderer.sv
// Directed self-checking bench for snake_line_renderer.
module tb_snake_line_renderer;

   logic          clock = 1'b0;
   logic          reset;
   logic [999:0]  pos_x, pos_y;
   logic [9:0]    length;
   logic          frame_start, line_start;
   logic [9:0]    line_y, pixel_x;
   logic          snake_body, snake_head, busy, scan_done;

   int n_checks = 0;
   int n_pass   = 0;

   snake_line_renderer dut (
      .clock(clock), .reset(reset), .pos_x(pos_x), .pos_y(pos_y), .length(length),
      .frame_start(frame_start), .line_start(line_start), .line_y(line_y),
      .pixel_x(pixel_x), .snake_body(snake_body), .snake_head(snake_head),
      .busy(busy), .scan_done(scan_done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic set_seg(input int k, input int x, input int y);
      pos_x[k*10 +: 10] = 10'(x);
      pos_y[k*10 +: 10] = 10'(y);
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
   endtask

   // Pulse line_start and report cycles until scan_done and how many of them had busy high.
   task automatic run_line(input int y, output int cycles, output int busy_cycles);
      bit seen = 1'b0;
      cycles = 0;
      busy_cycles = 0;
      line_y = 10'(y);
      line_start = 1'b1;
      while (!seen && cycles < 300) begin
         @(negedge clock);
         line_start = 1'b0;
         cycles++;
         if (busy) busy_cycles++;
         if (scan_done) seen = 1'b1;
      end
   endtask

   task automatic probe(input string tag, input int px, input logic eb, input logic eh);
      pixel_x = 10'(px);
      @(negedge clock);
      check({tag, "_body"}, {31'd0, snake_body}, {31'd0, eb});
      check({tag, "_head"}, {31'd0, snake_head}, {31'd0, eh});
   endtask

   task automatic count_done(input int n, output int dones);
      dones = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         line_start = 1'b0;
         if (scan_done) dones++;
      end
   endtask

   initial begin
      int lat, bcy, dn;
      reset = 1'b1; pos_x = '0; pos_y = '0; length = 10'd0;
      frame_start = 1'b0; line_start = 1'b0; line_y = 10'd0; pixel_x = 10'd0;
      repeat (3) @(negedge clock);
      check("rst_body", {31'd0, snake_body}, 32'd0);
      check("rst_head", {31'd0, snake_head}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, scan_done}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Single head segment at (320,120).
      set_seg(0, 320, 120); length = 10'd1;
      pulse_frame();
      run_line(125, lat, bcy);
      check("len1_latency", lat, 32'd3);
      check("len1_busy", bcy, 32'd2);
      @(negedge clock);
      check("done_one_pulse", {31'd0, scan_done}, 32'd0);
      probe("l125_319", 319, 1'b0, 1'b0);
      probe("l125_320", 320, 1'b1, 1'b1);
      probe("l125_329", 329, 1'b1, 1'b1);
      probe("l125_330", 330, 1'b0, 1'b0);
      run_line(130, lat, bcy);
      probe("l130_325", 325, 1'b0, 1'b0);
      run_line(120, lat, bcy);
      probe("l120_320", 320, 1'b1, 1'b1);
      probe("l120_329", 329, 1'b1, 1'b1);

      // 100 segments 10 px apart on row 200; only the first 64 are visible.
      for (int k = 0; k < 100; k++) set_seg(k, 10 * k, 200);
      length = 10'd100;
      pulse_frame();
      run_line(205, lat, bcy);
      check("len100_latency", lat, 32'd102);
      check("len100_busy", bcy, 32'd101);
      probe("full_0", 0, 1'b1, 1'b1);
      probe("full_9", 9, 1'b1, 1'b1);
      probe("full_10", 10, 1'b1, 1'b0);
      probe("full_320", 320, 1'b1, 1'b0);
      probe("full_639", 639, 1'b1, 1'b0);
      probe("full_640", 640, 1'b0, 1'b0);
      probe("full_1000", 1000, 1'b0, 1'b0);
      length = 10'd1023;
      pulse_frame();
      run_line(205, lat, bcy);
      check("clamp_latency", lat, 32'd102);

      // Right-edge clipping with a duplicate segment.
      set_seg(0, 635, 50); set_seg(1, 635, 50); length = 10'd2;
      pulse_frame();
      run_line(50, lat, bcy);
      check("dup_latency", lat, 32'd4);
      probe("clip_634", 634, 1'b0, 1'b0);
      probe("clip_635", 635, 1'b1, 1'b1);
      probe("clip_639", 639, 1'b1, 1'b1);
      probe("clip_0", 0, 1'b0, 1'b0);
      probe("clip_4", 4, 1'b0, 1'b0);

      // Restart mid-scan: line 10 hits only segment 1, line 125 hits the rest.
      for (int k = 0; k < 20; k++) set_seg(k, 320, 120);
      set_seg(1, 500, 5); length = 10'd20;
      pulse_frame();
      line_y = 10'd10; line_start = 1'b1;
      count_done(5, dn);
      line_y = 10'd125; line_start = 1'b1;
      begin
         int dn2;
         count_done(40, dn2);
         check("restart_dones", dn + dn2, 32'd1);
      end
      probe("restart_500", 500, 1'b0, 1'b0);
      probe("restart_320", 320, 1'b1, 1'b1);
      // Display keeps the previous line while a new scan runs.
      pixel_x = 10'd320; line_y = 10'd10; line_start = 1'b1;
      @(negedge clock); line_start = 1'b0;
      @(negedge clock); @(negedge clock);
      check("disp_kept", {31'd0, snake_body}, 32'd1);
      count_done(30, dn);
      probe("l10_320", 320, 1'b0, 1'b0);
      probe("l10_500", 500, 1'b1, 1'b0);

      // Reset mid-scan.
      line_y = 10'd125; line_start = 1'b1;
      count_done(5, dn);
      reset = 1'b1;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      count_done(40, dn);
      check("midrst_dones", dn, 32'd0);
      probe("midrst_320", 320, 1'b0, 1'b0);
      probe("midrst_500", 500, 1'b0, 1'b0);

      // Simultaneous frame_start and line_start.
      set_seg(0, 100, 60); length = 10'd1;
      pulse_frame();
      run_line(60, lat, bcy);
      set_seg(0, 200, 60);
      pixel_x = 10'd100;
      frame_start = 1'b1; line_start = 1'b1; line_y = 10'd60;
      @(negedge clock); frame_start = 1'b0; line_start = 1'b0;
      @(negedge clock);
      check("frame_clears_disp", {31'd0, snake_body}, 32'd0);
      @(negedge clock);
      check("frame_line_done", {31'd0, scan_done}, 32'd1);
      probe("fl_100", 100, 1'b0, 1'b0);
      probe("fl_200", 200, 1'b1, 1'b1);

      // Zero length produces empty masks.
      length = 10'd0;
      pulse_frame();
      line_y = 10'd60; line_start = 1'b1;
      count_done(10, dn);
      probe("len0_200", 200, 1'b0, 1'b0);
      probe("len0_205", 205, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
